branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Branch resolution stage for the 8-bit core. Selects two compare operands from NSRC register-file/forward
//  sources, evaluates the branch condition, computes the PC-relative target, and registers the result.
//  On a taken branch, drives a multi-cycle front-end flush and blocks new branches until the flush completes.
//  Sits between register read and fetch; replaces the fixed two-way branch operand select.
// PARAMETERS
//  WIDTH         8   operand/offset width (bits)
//  NSRC          4   number of operand sources (>=2); source 0 = R0
//  PC_W          10  program counter width
//  FLUSH_CYCLES  2   cycles flush held after a taken branch (>=1)
// PORTS
//  CLK        in   1              clock, all state on rising edge
//  reset      in   1              synchronous, active-high reset
//  br_valid   in   1              branch request present this cycle
//  br_ready   out  1              unit can accept a request (low during FLUSH)
//  stall      in   1              pipeline stall: blocks accept, freezes flush counter
//  src        in   NSRC*WIDTH     packed operand sources, src[i*WIDTH +: WIDTH] = source i
//  sel_a      in   $clog2(NSRC)   source index for operand A
//  sel_b      in   $clog2(NSRC)   source index for operand B
//  cond       in   2              0=EQ 1=NE 2=LTU (A<B unsigned) 3=LTS (A<B signed)
//  pc_in      in   PC_W           PC of the branch instruction
//  offset     in   WIDTH          signed two's-complement branch offset
//  res_valid  out  1              one-cycle pulse: taken/target valid
//  taken      out  1              condition result for last accepted branch
//  target     out  PC_W           pc_in + sext(offset), mod 2^PC_W
//  flush      out  1              front-end flush request
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, res_valid=0, taken=0, target=0, flush=0, counter=0; br_ready=1 after.
//  - Accept = br_valid & br_ready & ~stall. br_ready = (state==IDLE); combinational from state only.
//  - Operand select: A=src[sel_a], B=src[sel_b]; index >= NSRC selects source 0.
//  - Compare: EQ A==B; NE A!=B; LTU unsigned A<B; LTS signed A<B. A==B gives LTU=LTS=0.
//  - Target: offset sign-extended (or truncated) to PC_W, added to pc_in, carry-out discarded (wraps).
//  - Latency 1: on accept edge, taken/target registered, res_valid=1 for exactly one cycle; taken/target hold
//    their value until the next accept. Non-accept cycles: res_valid=0.
//  - FSM: IDLE -> FLUSH on accept with taken=1 (counter loaded FLUSH_CYCLES-1, flush=1 same edge as res_valid).
//    IDLE stays IDLE on not-taken accept (flush stays 0). FLUSH: if ~stall, counter decrements; at counter==0
//    and ~stall -> IDLE, flush=0 next cycle. So flush is high exactly FLUSH_CYCLES non-stalled cycles.
//  - stall in FLUSH: counter and flush held; stall in IDLE: no accept, outputs hold, res_valid=0.
//  - br_valid during FLUSH: ignored (not queued); requester must hold br_valid until accepted.
//  - Reset mid-FLUSH: immediate return to IDLE, flush=0 on next cycle, pending result discarded.
//  - Reset has priority over accept and stall in the same cycle.
// STRUCTURE
//  - branch_pkg: typedef enum logic[1:0] br_cond_t {BR_EQ,BR_NE,BR_LTU,BR_LTS}; typedef enum logic br_state_t
//    {BR_IDLE,BR_FLUSH}; shared by decoder and this block.
//  - Sub-module br_operand_mux #(WIDTH,NSRC): combinational N-way select with out-of-range->source 0;
//    instantiated twice (A, B). Compare, adder, FSM and counter live in this module.
//  - Counter width $clog2(FLUSH_CYCLES)+1; no latches, all regs in one always_ff.
// TESTING
//  1. src={8'h05,8'h05,...}, sel_a=0 sel_b=1 cond=EQ pc=10'h010 off=8'hFC -> next cycle res_valid=1 taken=1
//     target=10'h00C, flush high 2 cycles, br_ready low 2 cycles.
//  2. A=8'h80 B=8'h01: cond=LTU -> taken=0, flush never asserts, br_ready stays 1; cond=LTS -> taken=1.
//  3. pc=10'h3FE off=8'h05 cond=NE A!=B -> target=10'h003 (wrap); sel_a=7 with NSRC=4 -> uses source 0.
//  4. Taken branch, stall=1 for 3 cycles mid-flush -> flush high 2+3=5 cycles total; br_valid during flush ignored,
//     accepted first cycle br_ready=1.
//  5. reset asserted in first FLUSH cycle -> next cycle flush=0 res_valid=0 taken=0 target=0, br_ready=1.
//  6. Back-to-back not-taken requests every cycle -> res_valid=1 each cycle, no gaps, flush=0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared branch types: condition encoding used by the decoder and the resolve stage,
// plus the resolve-stage FSM state.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_LTU = 2'd2,
    BR_LTS = 2'd3
  } br_cond_t;

  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_FLUSH = 1'b1
  } br_state_t;

endpackage

// File: rtl/br_operand_mux.sv
// Combinational N-way operand select; an index beyond the last source falls back to source 0 (R0).
module br_operand_mux #(
  parameter int WIDTH = 8,
  parameter int NSRC  = 4
) (
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic [$clog2(NSRC)-1:0] sel,
  output logic [WIDTH-1:0]        out
);

  localparam int SW = $clog2(NSRC);

  always_comb begin
    out = src[WIDTH-1:0];
    for (int i = 1; i < NSRC; i++) begin
      if (sel == SW'(i)) out = src[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: operand select, condition compare, PC-relative target,
// and a multi-cycle front-end flush after a taken branch.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NSRC         = 4,
  parameter int PC_W         = 10,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    br_valid,
  output logic                    br_ready,
  input  logic                    stall,
  input  logic [NSRC*WIDTH-1:0]   src,
  input  logic [$clog2(NSRC)-1:0] sel_a,
  input  logic [$clog2(NSRC)-1:0] sel_b,
  input  logic [1:0]              cond,
  input  logic [PC_W-1:0]         pc_in,
  input  logic [WIDTH-1:0]        offset,
  output logic                    res_valid,
  output logic                    taken,
  output logic [PC_W-1:0]         target,
  output logic                    flush,
  output br_state_t               dbg_state
);

  localparam int CW = $clog2(FLUSH_CYCLES) + 1;

  // Handshake: a request transfers on a rising edge where br_valid & br_ready & ~stall.
  // br_valid is never queued; the requester holds it (and its operands) until it transfers.

  br_state_t         state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [PC_W-1:0]   off_ext;
  logic              hit;
  logic              accept;

  br_operand_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) u_mux_a (.src(src), .sel(sel_a), .out(op_a));
  br_operand_mux #(.WIDTH(WIDTH), .NSRC(NSRC)) u_mux_b (.src(src), .sel(sel_b), .out(op_b));

  generate
    if (PC_W > WIDTH) begin : g_sext
      assign off_ext = {{(PC_W-WIDTH){offset[WIDTH-1]}}, offset};
    end else begin : g_trunc
      assign off_ext = offset[PC_W-1:0];
    end
  endgenerate

  always_comb begin
    hit = 1'b0;
    case (br_cond_t'(cond))
      BR_EQ:   hit = (op_a == op_b);
      BR_NE:   hit = (op_a != op_b);
      BR_LTU:  hit = (op_a < op_b);
      BR_LTS:  hit = ($signed(op_a) < $signed(op_b));
      default: hit = 1'b0;
    endcase
  end

  assign br_ready  = (state == BR_IDLE);
  assign accept    = br_valid & br_ready & ~stall;
  assign dbg_state = state;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= BR_IDLE;
      res_valid <= 1'b0;
      taken     <= 1'b0;
      target    <= '0;
      flush     <= 1'b0;
      cnt       <= '0;
    end else begin
      res_valid <= accept;
      case (state)
        BR_IDLE: begin
          if (accept) begin
            taken  <= hit;
            target <= pc_in + off_ext;
            if (hit) begin
              state <= BR_FLUSH;
              flush <= 1'b1;
              cnt   <= CW'(FLUSH_CYCLES - 1);
            end
          end
        end
        BR_FLUSH: begin
          // Stall freezes the countdown, stretching the flush by the stalled cycles.
          if (!stall) begin
            if (cnt == '0) begin
              state <= BR_IDLE;
              flush <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= BR_IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: compare conditions, target wrap, flush timing,
// stall stretching, reset mid-flush, back-to-back accepts, out-of-range operand select.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid, stall;
  logic [31:0] src;
  logic [1:0]  sel_a, sel_b, cond;
  logic [9:0]  pc_in;
  logic [7:0]  offset;
  logic        br_ready, res_valid, taken, flush;
  logic [9:0]  target;
  br_state_t   dbg_state;

  // Second instance with NSRC=5 so a 3-bit select can exceed the source count.
  logic [39:0] src5;
  logic [2:0]  sel_a5, sel_b5;
  logic        br_ready5, res_valid5, taken5, flush5;
  logic [9:0]  target5;
  br_state_t   dbg_state5;

  int checks = 0;
  int failures = 0;
  int nflush;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .CLK(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready), .stall(stall),
    .src(src), .sel_a(sel_a), .sel_b(sel_b), .cond(cond), .pc_in(pc_in), .offset(offset),
    .res_valid(res_valid), .taken(taken), .target(target), .flush(flush), .dbg_state(dbg_state)
  );

  branch_resolve_unit #(.NSRC(5)) dut5 (
    .CLK(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready5), .stall(stall),
    .src(src5), .sel_a(sel_a5), .sel_b(sel_b5), .cond(cond), .pc_in(pc_in), .offset(offset),
    .res_valid(res_valid5), .taken(taken5), .target(target5), .flush(flush5), .dbg_state(dbg_state5)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                       input logic [9:0] pc, input logic [7:0] off);
    sel_a  = a;
    sel_b  = b;
    sel_a5 = {1'b0, a};
    sel_b5 = {1'b0, b};
    cond   = c;
    pc_in  = pc;
    offset = off;
  endtask

  task automatic set_src(input logic [31:0] s);
    src  = s;
    src5 = {8'hEE, s};
  endtask

  initial begin
    reset = 1'b1; br_valid = 1'b0; stall = 1'b0;
    set_src(32'h0);
    drive(2'd0, 2'd0, 2'd0, 10'h0, 8'h0);
    tick(); tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_taken", taken, 0);
    check("rst_target", target, 0);
    check("rst_flush", flush, 0);
    check("rst_ready", br_ready, 1);
    reset = 1'b0;
    tick();
    check("idle_ready", br_ready, 1);
    check("idle_res_valid", res_valid, 0);

    // 1: EQ taken, negative offset, flush for 2 cycles
    set_src({8'h55, 8'hAA, 8'h05, 8'h05});
    drive(2'd0, 2'd1, BR_EQ, 10'h010, 8'hFC);
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    check("t1_res_valid", res_valid, 1);
    check("t1_taken", taken, 1);
    check("t1_target", target, 10'h00C);
    check("t1_flush0", flush, 1);
    check("t1_ready0", br_ready, 0);
    check("t1_state", dbg_state, BR_FLUSH);
    tick();
    check("t1_res_pulse", res_valid, 0);
    check("t1_flush1", flush, 1);
    check("t1_ready1", br_ready, 0);
    tick();
    check("t1_flush_end", flush, 0);
    check("t1_ready_end", br_ready, 1);

    // 2: A=80 B=01, LTU not taken then LTS taken
    set_src({8'h01, 8'h80, 8'h05, 8'h05});
    drive(2'd2, 2'd3, BR_LTU, 10'h040, 8'h10);
    br_valid = 1'b1;
    tick();
    check("t2_ltu_valid", res_valid, 1);
    check("t2_ltu_taken", taken, 0);
    check("t2_ltu_target", target, 10'h050);
    check("t2_ltu_flush", flush, 0);
    check("t2_ltu_ready", br_ready, 1);
    cond = BR_LTS;
    tick();
    br_valid = 1'b0;
    check("t2_lts_valid", res_valid, 1);
    check("t2_lts_taken", taken, 1);
    check("t2_lts_flush", flush, 1);
    tick(); tick();
    check("t2_idle", br_ready, 1);

    // 6: back-to-back not-taken, one result per cycle
    drive(2'd2, 2'd3, BR_LTU, 10'h100, 8'h02);
    br_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_valid", res_valid, 1);
      check("t6_target", target, 32'(10'h102 + 10'(i)));
      check("t6_flush", flush, 0);
      pc_in = pc_in + 10'd1;
    end
    br_valid = 1'b0;
    tick();
    check("t6_gap", res_valid, 0);

    // 4: taken branch, 3 stall cycles mid-flush, br_valid held throughout
    set_src({8'h55, 8'hAA, 8'h05, 8'h05});
    drive(2'd0, 2'd1, BR_EQ, 10'h020, 8'h04);
    br_valid = 1'b1;
    tick();
    nflush = 0;
    if (flush) nflush++;
    check("t4_target", target, 10'h024);
    drive(2'd0, 2'd1, BR_NE, 10'h100, 8'h04);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (flush) nflush++;
      check("t4_stall_ready", br_ready, 0);
      check("t4_stall_resv", res_valid, 0);
      check("t4_stall_target", target, 10'h024);
    end
    stall = 1'b0;
    for (int i = 0; i < 10 && flush; i++) begin
      tick();
      if (flush) nflush++;
    end
    check("t4_flush_len", nflush, 5);
    check("t4_flush_done", flush, 0);
    check("t4_ready", br_ready, 1);
    check("t4_no_accept", res_valid, 0);
    tick();
    br_valid = 1'b0;
    check("t4_accept_valid", res_valid, 1);
    check("t4_accept_taken", taken, 0);
    check("t4_accept_target", target, 10'h104);

    // 5: reset in first flush cycle
    drive(2'd0, 2'd1, BR_EQ, 10'h030, 8'h08);
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    check("t5_flush", flush, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_flush", flush, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_taken", taken, 0);
    check("t5_target", target, 0);
    check("t5_ready", br_ready, 1);
    check("t5_state", dbg_state, BR_IDLE);

    // 3: target wraps; out-of-range select on the 5-source instance reads source 0
    set_src({8'h44, 8'h33, 8'h22, 8'h11});
    drive(2'd0, 2'd1, BR_NE, 10'h3FE, 8'h05);
    sel_a5 = 3'd7;
    sel_b5 = 3'd0;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    check("t3_taken", taken, 1);
    check("t3_target_wrap", target, 10'h003);
    check("t3_oor_valid", res_valid5, 1);
    check("t3_oor_taken", taken5, 0);
    check("t3_oor_target", target5, 10'h003);
    sel_a5 = 3'd4;
    cond = BR_EQ;
    br_valid = 1'b1;
    tick();
    br_valid = 1'b0;
    check("t3_src4_taken", taken5, 0);
    check("t3_src4_valid", res_valid5, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
